// File: rtl/pe_cfg_pkg.sv
// pe_cfg_pkg
// Shared definitions for the PE configuration loader:
//   - state_e       : loader FSM states (IDLE, WLOAD, CLOAD, DONE)
//   - KSQ           : kernel size squared (3x3 kernel -> 9 weights per PE)
//   - field offsets : control word layout {d_ch, bp_ch, bp_src}, bp_src in LSBs
package pe_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WLOAD = 2'd1,
    CLOAD = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int KSQ = 9;

  localparam int BP_SRC_OFF = 0;

  // bp_ch sits directly above bp_src
  function automatic int bp_ch_off(input int cl1);
    return cl1;
  endfunction

  // d_ch sits above bp_ch
  function automatic int d_ch_off(input int cl1, input int cl_in);
    return cl1 + cl_in;
  endfunction

endpackage

// File: rtl/pe_cfg_if.sv
// pe_cfg_if
// Host configuration word stream (valid/ready handshake).
//   cfg_valid : host word valid   (host -> loader)
//   cfg_ready : loader accepts    (loader -> host)
//   cfg_data  : host word, DW bits (host -> loader)
// Modports: master = host side, slave = loader side.
interface pe_cfg_if #(
  parameter int DW = 10
);

  logic          cfg_valid;
  logic          cfg_ready;
  logic [DW-1:0] cfg_data;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);

endinterface

// File: rtl/pe_cfg_loader_check.sv
// pe_cfg_check
// Combinational sanity check of one control word {d_ch, bp_ch, bp_src}.
//   word : control word, 2*CL_IN+CL1 bits
//   err  : 1 when a channel both computes and bypasses, or when a bypass
//          is requested from a source index outside the channel range
// Only instantiated when PE_CFG_CHECK_EN is defined.
module pe_cfg_check
  import pe_cfg_pkg::*;
#(
  parameter int CL_IN = 4,
  parameter int CL1   = 2
) (
  input  logic [2*CL_IN+CL1-1:0] word,
  output logic                   err
);

  localparam int BP_CH_LSB = bp_ch_off(CL1);
  localparam int D_CH_LSB  = d_ch_off(CL1, CL_IN);

  logic [CL_IN-1:0] d_ch;
  logic [CL_IN-1:0] bp_ch;
  logic [CL1-1:0]   bp_src;

  always_comb begin
    d_ch   = word[D_CH_LSB +: CL_IN];
    bp_ch  = word[BP_CH_LSB +: CL_IN];
    bp_src = word[BP_SRC_OFF +: CL1];
    err    = (|(d_ch & bp_ch)) || ((|bp_ch) && (int'(bp_src) >= CL_IN));
  end

endmodule

// File: rtl/pe_cfg_loader.sv
// pe_cfg_loader
// Feeds a daisy-chained PE column from a host word stream: first NW weights
// over the serial weight chain, then NUM_PE control words over the control
// chain, then a one-cycle done pulse.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : request a load (ignored while busy)
//   busy, done        : load in progress / completion pulse
//   cfg (slave)       : host valid/ready word stream
//   w_conf, w_out     : weight shift enable and weight to PE0
//   cntl_conf         : control shift enable to PE0
//   d_ch_out, bp_ch_out, bp_src_out : control fields to PE0
//   err               : sticky control-word check flag
// Build option: define PE_CFG_CHECK_EN to compile in the control-word check;
// otherwise err is tied to 0.
module pe_cfg_loader
  import pe_cfg_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int CL_IN  = 4,
  parameter int CL1    = 2,
  parameter int M      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  pe_cfg_if.slave          cfg,
  output logic             w_conf,
  output logic [M-1:0]     w_out,
  output logic             cntl_conf,
  output logic [CL_IN-1:0] d_ch_out,
  output logic [CL_IN-1:0] bp_ch_out,
  output logic [CL1-1:0]   bp_src_out,
  output logic             err
);

  localparam int CW        = 2*CL_IN + CL1;
  localparam int DW        = (M > CW) ? M : CW;
  localparam int NW        = KSQ * NUM_PE;
  localparam int WCW       = $clog2(NW + 1);
  localparam int PCW       = $clog2(NUM_PE + 1);
  localparam int BP_CH_LSB = bp_ch_off(CL1);
  localparam int D_CH_LSB  = d_ch_off(CL1, CL_IN);

  state_e           state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [PCW-1:0]   pcnt_q, pcnt_d;
  logic             w_conf_q, w_conf_d;
  logic [M-1:0]     w_out_q, w_out_d;
  logic             cntl_conf_q, cntl_conf_d;
  logic [CL_IN-1:0] d_ch_q, d_ch_d;
  logic [CL_IN-1:0] bp_ch_q, bp_ch_d;
  logic [CL1-1:0]   bp_src_q, bp_src_d;
  logic             done_q, done_d;

  logic [DW-1:0]    word;
  logic             ready_c;
  logic             hs;

  assign word          = cfg.cfg_data;
  assign ready_c       = (state_q == WLOAD) || (state_q == CLOAD);
  assign cfg.cfg_ready = ready_c;
  assign hs            = cfg.cfg_valid & ready_c;

`ifdef PE_CFG_CHECK_EN
  logic err_q, err_d;
  logic chk_err;

  pe_cfg_check #(
    .CL_IN (CL_IN),
    .CL1   (CL1)
  ) u_check (
    .word (word[CW-1:0]),
    .err  (chk_err)
  );

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // done is registered off the DONE state so the pulse lands one cycle
  // after the final cntl_conf; busy stays up through that pulse cycle,
  // which is also why a start seen while done_q is high is dropped.
  assign done = done_q;
  assign busy = (state_q != IDLE) || done_q;

  assign w_conf     = w_conf_q;
  assign w_out      = w_out_q;
  assign cntl_conf  = cntl_conf_q;
  assign d_ch_out   = d_ch_q;
  assign bp_ch_out  = bp_ch_q;
  assign bp_src_out = bp_src_q;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    pcnt_d      = pcnt_q;
    w_conf_d    = 1'b0;
    w_out_d     = w_out_q;
    cntl_conf_d = 1'b0;
    d_ch_d      = d_ch_q;
    bp_ch_d     = bp_ch_q;
    bp_src_d    = bp_src_q;
    done_d      = (state_q == DONE);
`ifdef PE_CFG_CHECK_EN
    err_d       = err_q;
`endif

    case (state_q)
      IDLE: begin
        wcnt_d = '0;
        pcnt_d = '0;
        if (start && !done_q) begin
          state_d = WLOAD;
`ifdef PE_CFG_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      WLOAD: begin
        if (hs) begin
          w_out_d  = word[M-1:0];
          w_conf_d = 1'b1;
          if (wcnt_q == WCW'(NW - 1)) begin
            state_d = CLOAD;
          end else begin
            wcnt_d = wcnt_q + WCW'(1);
          end
        end
      end
      CLOAD: begin
        if (hs) begin
          d_ch_d      = word[D_CH_LSB +: CL_IN];
          bp_ch_d     = word[BP_CH_LSB +: CL_IN];
          bp_src_d    = word[BP_SRC_OFF +: CL1];
          cntl_conf_d = 1'b1;
`ifdef PE_CFG_CHECK_EN
          if (chk_err) begin
            err_d = 1'b1;
          end
`endif
          if (pcnt_q == PCW'(NUM_PE - 1)) begin
            state_d = DONE;
          end else begin
            pcnt_d = pcnt_q + PCW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      pcnt_q      <= '0;
      w_conf_q    <= 1'b0;
      w_out_q     <= '0;
      cntl_conf_q <= 1'b0;
      d_ch_q      <= '0;
      bp_ch_q     <= '0;
      bp_src_q    <= '0;
      done_q      <= 1'b0;
`ifdef PE_CFG_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      pcnt_q      <= pcnt_d;
      w_conf_q    <= w_conf_d;
      w_out_q     <= w_out_d;
      cntl_conf_q <= cntl_conf_d;
      d_ch_q      <= d_ch_d;
      bp_ch_q     <= bp_ch_d;
      bp_src_q    <= bp_src_d;
      done_q      <= done_d;
`ifdef PE_CFG_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

endmodule
